fetch_unit: RTL and testbench

- Instruction-fetch front end for the RV64I/Zba five-stage pipeline.
- Owns the PC register, the instruction-memory request/response handshake, and the IF/ID pipeline register.
- Consumes the hazard controls (StallF, StallD, FlushD) and branch redirects (PCSrc_E, PCTarget_E).
- Reports FetchBusy back to hazard control.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_if_id_reg.sv | 44 ++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] BUBBLE = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  logic [ILEN-1:0] word,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [ILEN-1:0] instr_q,
  output logic [XLEN-1:0] pc_q,
  output logic [XLEN-1:0] pc_plus4_q,
  output logic            valid_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= BUBBLE;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (flush) begin
      instr_q <= BUBBLE;
      valid_q <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        instr_q    <= word;
        pc_q       <= pc;
        pc_plus4_q <= pc_plus4;
        valid_q    <= 1'b1;
      end else begin
        // Bubble keeps the last PC pair so debug views stay meaningful.
        instr_q <= BUBBLE;
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, single-outstanding imem handshake, IF/ID register.
// Define FETCH_PERF_EN to add saturating fetched/squashed/stall-cycle counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
  parameter logic [ILEN-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrc_E,
  input  logic [XLEN-1:0] PCTarget_E,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] Instr_D,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PCPlus4_D,
  output logic            Valid_D,
  output logic            FetchBusy
`ifdef FETCH_PERF_EN
  ,
  output logic [63:0]     perf_fetched,
  output logic [63:0]     perf_squashed,
  output logic [63:0]     perf_stall_cyc
`endif
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc_f, pc_next, req_pc, req_pc_plus4;
  logic [ILEN-1:0] hold_word, deliver_word;
  logic            handshake, deliver, latch_hold;

  assign imem_req     = (state == S_REQ) & ~StallF & ~rst;
  assign imem_addr    = pc_f;
  assign handshake    = imem_req & imem_gnt;
  assign req_pc_plus4 = req_pc + 64'd4;
  assign FetchBusy    = (state == S_REQ) | (state == S_DROP) |
                        ((state == S_WAIT) & ~imem_rvalid);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next   = state;
    pc_next      = pc_f;
    deliver      = 1'b0;
    deliver_word = imem_rdata;
    latch_hold   = 1'b0;
    if (PCSrc_E) begin
      // Redirect wins: the in-flight response, if any, is thrown away.
      pc_next = PCTarget_E;
      case (state)
        S_REQ:   state_next = handshake ? S_DROP : S_REQ;
        S_WAIT:  state_next = imem_rvalid ? S_REQ : S_DROP;
        S_HOLD:  state_next = S_REQ;
        S_DROP:  state_next = imem_rvalid ? S_REQ : S_DROP;
        default: state_next = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: if (handshake) state_next = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid && !StallD) begin
            deliver    = 1'b1;
            pc_next    = req_pc_plus4;
            state_next = S_REQ;
          end else if (imem_rvalid) begin
            latch_hold = 1'b1;
            state_next = S_HOLD;
          end
        end
        S_HOLD: begin
          deliver_word = hold_word;
          if (!StallD) begin
            deliver    = 1'b1;
            pc_next    = req_pc_plus4;
            state_next = S_REQ;
          end
        end
        S_DROP:  if (imem_rvalid) state_next = S_REQ;
        default: state_next = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= S_REQ;
      pc_f      <= RESET_PC;
      req_pc    <= '0;
      hold_word <= NOP_INSTR;
    end else begin
      state <= state_next;
      pc_f  <= pc_next;
      if (handshake)  req_pc    <= pc_f;
      if (latch_hold) hold_word <= imem_rdata;
    end
  end

  if_id_reg #(.BUBBLE(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .stall      (StallD),
    .flush      (FlushD | PCSrc_E),
    .load       (deliver),
    .word       (deliver_word),
    .pc         (req_pc),
    .pc_plus4   (req_pc_plus4),
    .instr_q    (Instr_D),
    .pc_q       (PC_D),
    .pc_plus4_q (PCPlus4_D),
    .valid_q    (Valid_D)
  );

`ifdef FETCH_PERF_EN
  logic squash;

  // A response arriving while dropping, or any response/held word hit by a redirect.
  assign squash = (imem_rvalid & (state == S_DROP)) |
                  (PCSrc_E & imem_rvalid & (state == S_WAIT)) |
                  (PCSrc_E & (state == S_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= '0;
      perf_squashed  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (deliver   && perf_fetched   != '1) perf_fetched   <= perf_fetched + 64'd1;
      if (squash    && perf_squashed  != '1) perf_squashed  <= perf_squashed + 64'd1;
      if (FetchBusy && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios, a latency-programmable
// memory responder, and a flag-level reference model compared on every cycle.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrc_E;
  logic [63:0] PCTarget_E;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata, Instr_D;
  logic [63:0] PC_D, PCPlus4_D;
  logic        Valid_D, FetchBusy;
`ifdef FETCH_PERF_EN
  logic [63:0] perf_fetched, perf_squashed, perf_stall_cyc;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrc_E(PCSrc_E), .PCTarget_E(PCTarget_E),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Instr_D(Instr_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D), .Valid_D(Valid_D),
    .FetchBusy(FetchBusy)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed),
    .perf_stall_cyc(perf_stall_cyc)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Instruction memory contents: address 8 holds addi x1,x0,5.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a == 64'h8) ? 32'h0050_0093 : {a[15:0], 16'h0113};
  endfunction

  // Memory responder: one response, mem_lat cycles after the accepted request.
  int          mem_lat = 1;
  int          mem_cnt;
  logic        mem_pend;
  logic [63:0] mem_addr;

  assign imem_rvalid = mem_pend && (mem_cnt == 0);
  assign imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
    end else begin
      if (imem_rvalid) mem_pend <= 1'b0;
      else if (mem_pend && mem_cnt != 0) mem_cnt <= mem_cnt - 1;
      if (imem_req && imem_gnt) begin
        mem_pend <= 1'b1;
        mem_cnt  <= mem_lat - 1;
        mem_addr <= imem_addr;
      end
    end
  end

  // Reference model: what the fetcher is doing, as flags rather than a state code.
  logic        m_pend, m_drop, m_held;
  logic [63:0] m_pc, m_rpc, m_pcd, m_pc4;
  logic [31:0] m_hword, m_instr;
  logic        m_valid;

  function automatic logic m_idle();
    return !m_pend && !m_drop && !m_held;
  endfunction

  always @(posedge clk) begin
    logic        hs, dlv, n_pend, n_drop, n_held;
    logic [31:0] dword;
    logic [63:0] n_pc;
    hs     = m_idle() && !StallF && imem_gnt;
    dlv    = 1'b0;
    dword  = '0;
    n_pend = m_pend;
    n_drop = m_drop;
    n_held = m_held;
    n_pc   = m_pc;
    if (rst) begin
      m_pend <= 1'b0; m_drop <= 1'b0; m_held <= 1'b0;
      m_pc <= 64'h0; m_rpc <= 64'h0;
      m_instr <= NOP; m_pcd <= 64'h0; m_pc4 <= 64'h0; m_valid <= 1'b0;
    end else begin
      if (PCSrc_E) begin
        n_pc   = PCTarget_E;
        n_drop = (m_idle() && hs) || ((m_pend || m_drop) && !imem_rvalid);
        n_pend = 1'b0;
        n_held = 1'b0;
      end else begin
        if (m_idle() && hs) begin
          n_pend = 1'b1;
          m_rpc <= m_pc;
        end
        if (m_pend && imem_rvalid) begin
          n_pend = 1'b0;
          if (!StallD) begin dlv = 1'b1; dword = imem_rdata; end
          else begin n_held = 1'b1; m_hword <= imem_rdata; end
        end
        if (m_held && !StallD) begin
          n_held = 1'b0;
          dlv = 1'b1;
          dword = m_hword;
        end
        if (m_drop && imem_rvalid) n_drop = 1'b0;
        if (dlv) n_pc = m_rpc + 64'd4;
      end
      m_pend <= n_pend; m_drop <= n_drop; m_held <= n_held; m_pc <= n_pc;
      if (FlushD || PCSrc_E) begin
        m_instr <= NOP; m_valid <= 1'b0;
      end else if (!StallD) begin
        if (dlv) begin
          m_instr <= dword; m_pcd <= m_rpc; m_pc4 <= m_rpc + 64'd4; m_valid <= 1'b1;
        end else begin
          m_instr <= NOP; m_valid <= 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc imem_req", imem_req, m_idle() && !StallF && !rst);
      check("cyc imem_addr", imem_addr, m_pc);
      check("cyc FetchBusy", FetchBusy, m_idle() || m_drop || (m_pend && !imem_rvalid));
      check("cyc Instr_D", Instr_D, m_instr);
      check("cyc PC_D", PC_D, m_pcd);
      check("cyc PCPlus4_D", PCPlus4_D, m_pc4);
      check("cyc Valid_D", Valid_D, m_valid);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrc_E = 1'b0; PCTarget_E = '0; imem_gnt = 1'b1;
    step();
    cmp_on = 1'b1;
    step(); step();
    #1;
    check("rst Valid_D", Valid_D, 0);
    check("rst Instr_D", Instr_D, NOP);
    check("rst PC_D", PC_D, 0);
    check("rst PCPlus4_D", PCPlus4_D, 0);
    check("rst imem_req", imem_req, 0);
    rst = 1'b0; #1;
    check("seq req0", imem_req, 1);
    check("seq addr0", imem_addr, 64'h0);
    step(); #1;
    check("seq wait Valid_D", Valid_D, 0);
    check("seq wait busy", FetchBusy, 0);
    step(); #1;
    check("seq addr4", imem_addr, 64'h4);
    check("seq Instr0", Instr_D, 32'h0000_0113);
    check("seq PC_D0", PC_D, 64'h0);
    check("seq PC4_D0", PCPlus4_D, 64'h4);
    check("seq Valid0", Valid_D, 1);
    step(); #1;
    check("seq bubble", Valid_D, 0);
    step(); #1;
    check("seq addr8", imem_addr, 64'h8);
    check("seq PC_D4", PC_D, 64'h4);
    // StallD across the response: word parks in the hold register.
    step(); StallD = 1'b1; #1;
    check("hold rvalid busy", FetchBusy, 0);
    step(); #1;
    check("hold req", imem_req, 0);
    check("hold busy", FetchBusy, 0);
    step();
    step(); StallD = 1'b0; #1;
    check("hold Valid_D", Valid_D, 0);
    step(); mem_lat = 3; #1;
    check("hold Instr", Instr_D, 32'h0050_0093);
    check("hold PC_D", PC_D, 64'h8);
    check("hold PC4", PCPlus4_D, 64'hC);
    check("hold next addr", imem_addr, 64'hC);
    // Redirect while waiting on a slow response.
    step(); PCSrc_E = 1'b1; PCTarget_E = 64'h100; #1;
    check("redir wait busy", FetchBusy, 1);
    step(); PCSrc_E = 1'b0; #1;
    check("redir Valid_D", Valid_D, 0);
    check("redir drop req", imem_req, 0);
    step(); mem_lat = 1;
    step(); #1;
    check("redir addr", imem_addr, 64'h100);
    check("redir req", imem_req, 1);
    check("redir Valid_D2", Valid_D, 0);
    // Redirect coincident with rvalid.
    step(); PCSrc_E = 1'b1; PCTarget_E = 64'h200; #1;
    check("coin rvalid", imem_rvalid, 1);
    step(); PCSrc_E = 1'b0; #1;
    check("coin addr", imem_addr, 64'h200);
    check("coin req", imem_req, 1);
    check("coin Valid_D", Valid_D, 0);
    // StallF for four cycles.
    StallF = 1'b1; #1;
    check("stallf req", imem_req, 0);
    step(); #1;
    check("stallf addr", imem_addr, 64'h200);
    check("stallf busy", FetchBusy, 1);
    step(); step();
    step(); StallF = 1'b0; #1;
    check("stallf resume req", imem_req, 1);
    check("stallf resume addr", imem_addr, 64'h200);
    // Reset while waiting.
    step(); rst = 1'b1;
    step(); #1;
    check("midrst addr", imem_addr, 64'h0);
    check("midrst Valid_D", Valid_D, 0);
    check("midrst Instr", Instr_D, NOP);
    // Redirect to the top word; PC+4 wraps to zero.
    step(); rst = 1'b0; PCSrc_E = 1'b1; PCTarget_E = 64'hFFFF_FFFF_FFFF_FFFC; StallF = 1'b1;
    step(); PCSrc_E = 1'b0; StallF = 1'b0; #1;
    check("wrap addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    step(); #1;
    check("wrap PC_D", PC_D, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap PC4", PCPlus4_D, 64'h0);
    check("wrap next addr", imem_addr, 64'h0);
    // Mixed hazard patterns, checked by the per-cycle model compare.
    for (int i = 0; i < 80; i++) begin
      step();
      imem_gnt   = (i % 3) != 0;
      StallD     = (i % 7) == 3 || (i % 7) == 4;
      FlushD     = (i % 11) == 5;
      StallF     = (i % 13) == 6;
      PCSrc_E    = (i % 17) == 9;
      PCTarget_E = 64'h40 + 64'(i) * 8;
      mem_lat    = 1 + (i % 3);
    end
    step();
    imem_gnt = 1'b1; StallD = 1'b0; FlushD = 1'b0; StallF = 1'b0; PCSrc_E = 1'b0;
    repeat (6) step();
    cmp_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
